alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter DATA_W, default 32: datapath width; sets the multiply pass count P_MUL = DATA_W.
REQ-002 Parameter CNT_W, default 6: pass-counter width; SHALL satisfy 2^CNT_W >= DATA_W (elaboration error otherwise).
REQ-003 Parameter MULT_EN, default 1: 1 enables multi-pass multiply decode; 0 treats func 011000 as illegal.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous abort of the current operation.
REQ-007 in_valid  input  1  aluOp/func presented this cycle.
REQ-008 in_ready  output  1  block accepts an operation this cycle.
REQ-009 aluOp  input  3  main-decoder ALU operation class.
REQ-010 func  input  6  R-type function field, used only when aluOp = 010.
REQ-011 gout  output  3  registered ALU control code.
REQ-012 gout_valid  output  1  gout is valid this cycle.
REQ-013 pass_idx  output  CNT_W  index of the current pass, 0-based.
REQ-014 last  output  1  current pass is the final pass of the operation.
REQ-015 err  output  1  current operation decoded as illegal.

Function
REQ-016 Accept SHALL occur when in_valid & in_ready at a rising edge; in_ready = rst_n & ~(gout_valid & ~last).
REQ-017 States: IDLE (gout_valid = 0 or last = 1) and RUN (gout_valid = 1, last = 0); an accept in either state starts a new operation.
REQ-018 Non-R decode (aluOp != 010): 000 -> 010; 001 -> 110; 011 -> 011; 100 -> 001; 1 pass each.
REQ-019 Other non-R aluOp values (101, 110, 111) SHALL be illegal.
REQ-020 R decode (aluOp = 010), single pass: 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111; 000010 -> 101.
REQ-021 R decode jmadd (100001): 2 passes, gout 010 on both.
REQ-022 R decode mult (011000, MULT_EN = 1): P_MUL passes, gout 100 on every pass.
REQ-023 Any other func with aluOp = 010 SHALL be illegal.
REQ-024 Illegal operation: 1 pass, gout = 010, err = 1; all legal operations drive err = 0.
REQ-025 Latency: an operation accepted at edge N SHALL drive pass 0 after edge N; pass k appears after edge N+k.
REQ-026 Every pass cycle SHALL have gout_valid = 1, pass_idx = k, and last = 1 only when k = P-1.
REQ-027 aluOp/func SHALL be sampled only at accept; later changes on the inputs SHALL NOT affect an operation in progress.
REQ-028 At the last pass cycle in_ready = 1; an accept then SHALL start the next operation's pass 0 on the following edge, with no bubble.
REQ-029 No accept at the last pass: the next edge SHALL give gout_valid = 0, last = 0, pass_idx = 0, err = 0, and gout holds its previous value.
REQ-030 in_valid while in_ready = 0 SHALL be ignored; the source must hold in_valid until accepted.
REQ-031 flush = 1 at an edge SHALL clear gout_valid, last, err and pass_idx, return to IDLE, and suppress any simultaneous accept; flush has priority over accept.
REQ-032 pass_idx SHALL never exceed P-1 and SHALL never wrap within an operation.
REQ-033 All outputs except in_ready SHALL be driven from flops.

Reset
REQ-034 rst_n low SHALL immediately force gout = 000, gout_valid = 0, last = 0, err = 0, pass_idx = 0, IDLE, and in_ready = 0.
REQ-035 Reset asserted mid-operation SHALL abandon the operation; no pass output SHALL appear after rst_n rises.
REQ-036 First accept is possible on the first rising edge with rst_n high.

Verification
REQ-037 aluOp 000, then 001, 011, 100, each presented with in_valid on consecutive cycles -> gout 010, 110, 011, 001 on consecutive cycles, each with last = 1 and err = 0.
REQ-038 aluOp 010 with func 101010, then 000010 -> gout 111 then 101; then func 100001 -> two cycles of gout 010, pass_idx 0 then 1, last only on the second, in_ready = 0 on the first.
REQ-039 Mult with DATA_W = 32, in_valid held high with a new op -> 32 cycles of gout 100, pass_idx 0..31, last at pass 31; the queued op's pass 0 appears on the next cycle.
REQ-040 Flush at mult pass 10 with in_valid high -> next cycle gout_valid = 0; the cycle after, pass 0 of the pending op.
REQ-041 Illegal inputs: func 111111 with aluOp 010, aluOp 110, and func 011000 with MULT_EN = 0 -> each gives one pass of gout 010 with err = 1 and last = 1.
REQ-042 rst_n pulsed low during jmadd pass 0 -> outputs zero immediately; after release there is no pass 1 and gout_valid stays 0.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq -- ALU control decoder with multi-pass sequencing.
//
// Decodes the main-decoder ALU class (aluOp) and, for R-type, the function
// field (func) into a 3-bit ALU control code. Most operations take a single
// pass. jmadd takes two passes. mult takes DATA_W passes when MULT_EN is set.
// Each pass is presented for one cycle with its index.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous abort; wins over a same-cycle accept
//   in_valid      aluOp/func offered this cycle
//   in_ready      accept possible (combinational, the only non-flop output)
//   aluOp, func   operation class / R-type function field
//   gout          ALU control code of the current pass
//   gout_valid    a pass is being presented this cycle
//   pass_idx      0-based index of the current pass
//   last          current pass is the final one of its operation
//   err           current operation decoded as illegal
module alu_ctrl_seq #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 6,
  parameter bit MULT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluOp,
  input  logic [5:0]       func,
  output logic [2:0]       gout,
  output logic             gout_valid,
  output logic [CNT_W-1:0] pass_idx,
  output logic             last,
  output logic             err
);

  if ((2 ** CNT_W) < DATA_W) begin : g_cnt_chk
    $error("alu_ctrl_seq: CNT_W too narrow to count DATA_W passes");
  end

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

  // Decoded operation: control code, illegal flag, index of the final pass.
  typedef struct packed {
    logic [2:0]       code;
    logic             ill;
    logic [CNT_W-1:0] plast;
  } dec_t;

  typedef enum logic {IDLE, RUN} state_t;

  dec_t             dec;
  state_t           state, state_n;
  logic             accept;
  logic [CNT_W-1:0] plast_q, plast_n, idx_n;
  logic [2:0]       gout_n;
  logic             vld_n, last_n, err_n;

  // Illegal operations fall through to code 010, single pass, ill = 1.
  always_comb begin
    dec.code  = 3'b010;
    dec.ill   = 1'b0;
    dec.plast = '0;
    case (aluOp)
      3'b000: dec.code = 3'b010;
      3'b001: dec.code = 3'b110;
      3'b011: dec.code = 3'b011;
      3'b100: dec.code = 3'b001;
      3'b010: begin
        case (func)
          6'b100000: dec.code = 3'b010;
          6'b100010: dec.code = 3'b110;
          6'b100100: dec.code = 3'b000;
          6'b100101: dec.code = 3'b001;
          6'b101010: dec.code = 3'b111;
          6'b000010: dec.code = 3'b101;
          6'b100001: dec.plast = CNT_W'(1);    // jmadd: two add passes
          6'b011000: begin
            if (MULT_EN) begin
              dec.code  = 3'b100;
              dec.plast = MUL_LAST;
            end else begin
              dec.ill = 1'b1;
            end
          end
          default: dec.ill = 1'b1;
        endcase
      end
      default: dec.ill = 1'b1;
    endcase
  end

  // Busy only while a multi-pass op has passes still to come; the final
  // pass cycle is already ready so the next op follows with no bubble.
  assign in_ready = rst_n & ~(gout_valid & ~last);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_n = IDLE;
    gout_n  = gout;          // code persists through idle and flush
    vld_n   = 1'b0;
    last_n  = 1'b0;
    err_n   = 1'b0;
    idx_n   = '0;
    plast_n = plast_q;
    if (!flush) begin
      if (accept) begin
        gout_n  = dec.code;
        vld_n   = 1'b1;
        err_n   = dec.ill;
        plast_n = dec.plast;
        last_n  = (dec.plast == '0);
        state_n = last_n ? IDLE : RUN;
      end else if (state == RUN) begin
        idx_n   = pass_idx + 1'b1;
        vld_n   = 1'b1;
        err_n   = err;
        last_n  = (idx_n == plast_q);
        state_n = last_n ? IDLE : RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gout       <= '0;
      gout_valid <= 1'b0;
      pass_idx   <= '0;
      last       <= 1'b0;
      err        <= 1'b0;
      plast_q    <= '0;
    end else begin
      state      <= state_n;
      gout       <= gout_n;
      gout_valid <= vld_n;
      pass_idx   <= idx_n;
      last       <= last_n;
      err        <= err_n;
      plast_q    <= plast_n;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid;
  logic [2:0] aluOp;
  logic [5:0] func;

  logic       in_ready, gout_valid, last, err;
  logic [2:0] gout;
  logic [5:0] pass_idx;
  logic       in_ready0, gout_valid0, last0, err0;
  logic [2:0] gout0;
  logic [5:0] pass_idx0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .aluOp(aluOp), .func(func), .gout(gout),
    .gout_valid(gout_valid), .pass_idx(pass_idx), .last(last), .err(err)
  );

  alu_ctrl_seq #(.DATA_W(32), .CNT_W(6), .MULT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready0), .aluOp(aluOp), .func(func), .gout(gout0),
    .gout_valid(gout_valid0), .pass_idx(pass_idx0), .last(last0), .err(err0)
  );

  // {gout, gout_valid, pass_idx, last, err, in_ready}
  wire [12:0] obs  = {gout, gout_valid, pass_idx, last, err, in_ready};
  wire [12:0] obs0 = {gout0, gout_valid0, pass_idx0, last0, err0, in_ready0};

  function automatic logic [12:0] ex(input logic [2:0] g, input logic v,
      input logic [5:0] i, input logic l, input logic e, input logic r);
    return {g, v, i, l, e, r};
  endfunction

  // Reference decode straight from the operation table.
  function automatic void ref_dec(input logic [2:0] op, input logic [5:0] fn,
      output logic [2:0] g, output logic e, output int n);
    g = 3'b010; e = 1'b0; n = 1;
    if (op == 3'b010) begin
      case (fn)
        6'b100000: g = 3'b010;
        6'b100010: g = 3'b110;
        6'b100100: g = 3'b000;
        6'b100101: g = 3'b001;
        6'b101010: g = 3'b111;
        6'b000010: g = 3'b101;
        6'b100001: n = 2;
        6'b011000: begin g = 3'b100; n = 32; end
        default:   e = 1'b1;
      endcase
    end else begin
      case (op)
        3'b000:  g = 3'b010;
        3'b001:  g = 3'b110;
        3'b011:  g = 3'b011;
        3'b100:  g = 3'b001;
        default: e = 1'b1;
      endcase
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; aluOp = 3'b000; func = 6'd0;
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0)) begin
      $display("FAIL reset_state obs=%b exp=%b", obs, ex(3'b000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0)); fails++;
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready got=%b exp=1", in_ready); fails++;
    end
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b010, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)) begin
      $display("FAIL first_accept obs=%b exp=%b", obs, ex(3'b010, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)); fails++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b010, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)) begin
      $display("FAIL first_idle obs=%b exp=%b", obs, ex(3'b010, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)); fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops[4]   = '{3'b000, 3'b001, 3'b011, 3'b100};
    logic [2:0] exp_g[4] = '{3'b010, 3'b110, 3'b011, 3'b001};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; aluOp = ops[i]; func = 6'($urandom);
      @(negedge clk);
      tests++;
      if (obs !== ex(exp_g[i], 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)) begin
        $display("FAIL nonr_%0d obs=%b exp=%b", i, obs, ex(exp_g[i], 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)); fails++;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b001, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)) begin
      $display("FAIL nonr_hold obs=%b exp=%b", obs, ex(3'b001, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)); fails++;
    end
  endtask

  task automatic test_rtype();
    in_valid = 1'b1; aluOp = 3'b010; func = 6'b101010;
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b111, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)) begin
      $display("FAIL rtype_slt obs=%b exp=%b", obs, ex(3'b111, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)); fails++;
    end
    func = 6'b000010;
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b101, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)) begin
      $display("FAIL rtype_srl obs=%b exp=%b", obs, ex(3'b101, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)); fails++;
    end
    func = 6'b100001;
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b010, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0)) begin
      $display("FAIL jmadd_p0 obs=%b exp=%b", obs, ex(3'b010, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0)); fails++;
    end
    aluOp = 3'b001;    // offered while busy, must wait for the last pass
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b010, 1'b1, 6'd1, 1'b1, 1'b0, 1'b1)) begin
      $display("FAIL jmadd_p1 obs=%b exp=%b", obs, ex(3'b010, 1'b1, 6'd1, 1'b1, 1'b0, 1'b1)); fails++;
    end
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b110, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)) begin
      $display("FAIL jmadd_next obs=%b exp=%b", obs, ex(3'b110, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)); fails++;
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    in_valid = 1'b1; aluOp = 3'b010; func = 6'b011000;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      tests++;
      if (obs !== ex(3'b100, 1'b1, 6'(k), k == 31, 1'b0, k == 31)) begin
        $display("FAIL mult_p%0d obs=%b exp=%b", k, obs, ex(3'b100, 1'b1, 6'(k), k == 31, 1'b0, k == 31)); fails++;
      end
      func = (k == 31) ? 6'b100100 : 6'($urandom);
      @(negedge clk);
    end
    tests++;
    if (obs !== ex(3'b000, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)) begin
      $display("FAIL mult_queued obs=%b exp=%b", obs, ex(3'b000, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)); fails++;
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    in_valid = 1'b1; aluOp = 3'b010; func = 6'b011000;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tests++;
      if (obs !== ex(3'b100, 1'b1, 6'(k), 1'b0, 1'b0, 1'b0)) begin
        $display("FAIL flush_mult_p%0d obs=%b exp=%b", k, obs, ex(3'b100, 1'b1, 6'(k), 1'b0, 1'b0, 1'b0)); fails++;
      end
      if (k == 10) begin flush = 1'b1; in_valid = 1'b1; aluOp = 3'b011; end
      @(negedge clk);
    end
    flush = 1'b0;
    tests++;
    if (obs !== ex(3'b100, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)) begin
      $display("FAIL flush_clear obs=%b exp=%b", obs, ex(3'b100, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)); fails++;
    end
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b011, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)) begin
      $display("FAIL flush_pending obs=%b exp=%b", obs, ex(3'b011, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)); fails++;
    end
    flush = 1'b1; aluOp = 3'b000;
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b011, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)) begin
      $display("FAIL flush_vs_accept obs=%b exp=%b", obs, ex(3'b011, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)); fails++;
    end
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [2:0] ops[4] = '{3'b010, 3'b110, 3'b101, 3'b111};
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; aluOp = ops[i]; func = 6'b111111;
      @(negedge clk);
      tests++;
      if (obs !== ex(3'b010, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1)) begin
        $display("FAIL illegal_%0d obs=%b exp=%b", i, obs, ex(3'b010, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1)); fails++;
      end
    end
    aluOp = 3'b100;
    @(negedge clk);
    tests++;
    if (obs !== ex(3'b001, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)) begin
      $display("FAIL illegal_err_clear obs=%b exp=%b", obs, ex(3'b001, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1)); fails++;
    end
    aluOp = 3'b010; func = 6'b011000;
    @(negedge clk);
    tests++;
    if (obs0 !== ex(3'b010, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1)) begin
      $display("FAIL mult_disabled obs=%b exp=%b", obs0, ex(3'b010, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1)); fails++;
    end
    tests++;
    if (obs !== ex(3'b100, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0)) begin
      $display("FAIL mult_enabled obs=%b exp=%b", obs, ex(3'b100, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0)); fails++;
    end
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (obs !== ex(3'b100, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)) begin
      $display("FAIL illegal_flush obs=%b exp=%b", obs, ex(3'b100, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)); fails++;
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; aluOp = 3'b010; func = 6'b100001;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (obs !== ex(3'b010, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0)) begin
      $display("FAIL rstmid_p0 obs=%b exp=%b", obs, ex(3'b010, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0)); fails++;
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== ex(3'b000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0)) begin
      $display("FAIL rstmid_async obs=%b exp=%b", obs, ex(3'b000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0)); fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== ex(3'b000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)) begin
        $display("FAIL rstmid_after_%0d obs=%b exp=%b", i, obs, ex(3'b000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1)); fails++;
      end
    end
  endtask

  typedef struct {
    logic [2:0] g;
    int         idx;
    logic       last;
    logic       e;
  } pass_t;

  // Model: an accepted op expands into its list of passes; one pass is shown
  // per cycle, and a new op is only taken once no passes are left waiting.
  task automatic test_random();
    logic [5:0] ftab[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b101010, 6'b000010, 6'b100001, 6'b011000};
    pass_t      rem[$];
    pass_t      p;
    logic [2:0] m_g = 3'b000, dg;
    logic       m_v = 1'b0, m_last = 1'b0, m_err = 1'b0, de;
    logic [5:0] m_idx = 6'd0;
    logic       m_rdy;
    int         n;
    for (int c = 0; c < 500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      aluOp    = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom);
      n        = int'($urandom_range(0, 9));
      func     = (n < 8) ? ftab[n] : 6'($urandom);
      m_rdy    = (rem.size() == 0);
      if (flush) begin
        rem.delete();
        m_v = 1'b0; m_idx = 6'd0; m_last = 1'b0; m_err = 1'b0;
      end else begin
        if (in_valid && m_rdy) begin
          ref_dec(aluOp, func, dg, de, n);
          for (int k = 0; k < n; k++) rem.push_back('{dg, k, k == n - 1, de});
        end
        if (rem.size() > 0) begin
          p = rem.pop_front();
          m_g = p.g; m_v = 1'b1; m_idx = 6'(p.idx); m_last = p.last; m_err = p.e;
        end else begin
          m_v = 1'b0; m_idx = 6'd0; m_last = 1'b0; m_err = 1'b0;
        end
      end
      @(negedge clk);
      tests++;
      if (obs !== ex(m_g, m_v, m_idx, m_last, m_err, rem.size() == 0)) begin
        $display("FAIL random_c%0d obs=%b exp=%b", c, obs, ex(m_g, m_v, m_idx, m_last, m_err, rem.size() == 0)); fails++;
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; aluOp = 3'b000; func = 6'd0;
    #1;
    test_reset();
    test_back_to_back();
    test_rtype();
    test_mult();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
